// File: rtl/alu_issue.sv
// alu_issue: sequences one request at a time through an external ALU
// (IDLE -> ISSUE -> CAPTURE -> RESP) and returns result/branch/error.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/ready/op/op1/op2 request handshake, opcode and operands
//   alu_ctrl/alu_a/alu_b       registered drive to the attached ALU
//   alu_result, alu_v/c/n/z    ALU result and flags, sampled in CAPTURE
//   rsp_valid/ready            response handshake
//   rsp_result/taken/err       architectural result, branch taken, bad op
//   ops_done                   wrapping count of completed responses
module alu_issue #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_op1,
   input  logic [31:0]      req_op2,
   output logic [2:0]       alu_ctrl,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic [31:0]      alu_result,
   input  logic             alu_v,
   input  logic             alu_c,
   input  logic             alu_n,
   input  logic             alu_z,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_taken,
   output logic             rsp_err,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE, ISSUE, CAPTURE, RESP
   } state_e;

   localparam logic [CNT_W-1:0] ONE = 1;

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      op1_q, op1_d;
   logic [31:0]      op2_q, op2_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      res_q, res_d;
   logic             tkn_q, tkn_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The ALU subtracts as B-A, so compare/sub ops present swapped operands.
   // Result packs {ctrl, a, b}; illegal ops drive all zeros.
   function automatic logic [66:0] route(
      input logic [3:0]  op,
      input logic [31:0] x,
      input logic [31:0] y
   );
      logic [2:0] c;
      logic       sw;
      logic       ok;
      c  = 3'b000;
      sw = 1'b0;
      ok = 1'b1;
      unique case (op)
         4'd0: c = 3'b000;
         4'd1: begin c = 3'b001; sw = 1'b1; end
         4'd2: c = 3'b010;
         4'd3: c = 3'b011;
         4'd4: begin c = 3'b101; sw = 1'b1; end
         4'd5: begin c = 3'b001; sw = 1'b1; end
         4'd8, 4'd9, 4'd10,
         4'd11, 4'd12, 4'd13: begin
            c  = 3'b001;
            sw = 1'b1;
         end
         default: ok = 1'b0;
      endcase
      if (!ok)
         return 67'd0;
      else if (sw)
         return {c, y, x};
      else
         return {c, x, y};
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      ctrl_d  = 3'b000;
      a_d     = 32'd0;
      b_d     = 32'd0;
      res_d   = res_q;
      tkn_d   = tkn_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = ISSUE;
               op_d    = req_op;
               op1_d   = req_op1;
               op2_d   = req_op2;
               {ctrl_d, a_d, b_d} = route(req_op, req_op1, req_op2);
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
            {ctrl_d, a_d, b_d} = route(op_q, op1_q, op2_q);
         end
         CAPTURE: begin
            state_d = RESP;
            res_d   = 32'd0;
            tkn_d   = 1'b0;
            err_d   = 1'b0;
            unique case (op_q)
               4'd0, 4'd1,
               4'd2, 4'd3: res_d = alu_result;
               4'd4:  res_d = {31'd0, alu_result[0]};
               4'd5:  res_d = {31'd0, ~alu_c};
               4'd8:  tkn_d = alu_z;
               4'd9:  tkn_d = ~alu_z;
               4'd10: tkn_d = alu_n ^ alu_v;
               4'd11: tkn_d = ~(alu_n ^ alu_v);
               4'd12: tkn_d = ~alu_c;
               4'd13: tkn_d = alu_c;
               default: err_d = 1'b1;
            endcase
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               res_d   = 32'd0;
               tkn_d   = 1'b0;
               err_d   = 1'b0;
               cnt_d   = cnt_q + ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= 4'd0;
         op1_q   <= 32'd0;
         op2_q   <= 32'd0;
         ctrl_q  <= 3'b000;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         res_q   <= 32'd0;
         tkn_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         tkn_q   <= tkn_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign alu_ctrl   = ctrl_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign rsp_result = res_q;
   assign rsp_taken  = tkn_q;
   assign rsp_err    = err_q;
   assign ops_done   = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: drives alu_issue with directed and random requests,
// models the attached ALU, and checks responses against a reference.
module tb_alu_issue;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [31:0]   req_op1;
   logic [31:0]   req_op2;
   logic [2:0]    alu_ctrl;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [31:0]   alu_result;
   logic          alu_v;
   logic          alu_c;
   logic          alu_n;
   logic          alu_z;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_result;
   logic          rsp_taken;
   logic          rsp_err;
   logic [CW-1:0] ops_done;

   int            n_chk;
   int            n_err;
   logic [CW-1:0] cnt_m;
   logic [32:0]   diff;

   alu_issue #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_v      (alu_v),
      .alu_c      (alu_c),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_taken  (rsp_taken),
      .rsp_err    (rsp_err),
      .ops_done   (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached ALU: 001/101 compute B+~A+1; 101 yields the signed
   // less-than of that subtraction in bit 0.
   always_comb begin
      diff  = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
      alu_c = diff[32];
      alu_v = (alu_b[31] != alu_a[31]) && (diff[31] != alu_b[31]);
      alu_result = 32'd0;
      case (alu_ctrl)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = diff[31:0];
         3'b010: alu_result = alu_a & alu_b;
         3'b011: alu_result = alu_a | alu_b;
         3'b101: alu_result = {31'd0, diff[31] ^ alu_v};
         default: alu_result = 32'd0;
      endcase
      alu_n = alu_result[31];
      alu_z = (alu_result == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic ref_model(input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic t,
                            output logic e);
      r = 32'd0;
      t = 1'b0;
      e = 1'b0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd5:  r = (a < b) ? 32'd1 : 32'd0;
         4'd8:  t = (a == b);
         4'd9:  t = (a != b);
         4'd10: t = ($signed(a) < $signed(b));
         4'd11: t = ($signed(a) >= $signed(b));
         4'd12: t = (a < b);
         4'd13: t = (a >= b);
         default: e = 1'b1;
      endcase
   endtask

   task automatic exp_drive(input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic [2:0] c,
                            output logic [31:0] xa, output logic [31:0] xb);
      c  = 3'b000;
      xa = a;
      xb = b;
      case (op)
         4'd0: c = 3'b000;
         4'd2: c = 3'b010;
         4'd3: c = 3'b011;
         4'd4: begin c = 3'b101; xa = b; xb = a; end
         4'd1, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
            c = 3'b001; xa = b; xb = a;
         end
         default: begin xa = 32'd0; xb = 32'd0; end
      endcase
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
      logic [31:0] er, ea, eb;
      logic        et, ee;
      logic [2:0]  ec;
      ref_model(op, a, b, er, et, ee);
      exp_drive(op, a, b, ec, ea, eb);
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_op1   = a;
      req_op2   = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op    = 4'($urandom);
      req_op1   = $urandom;
      req_op2   = $urandom;
      chk("issue_ctrl", {29'd0, alu_ctrl}, {29'd0, ec});
      chk("issue_a", alu_a, ea);
      chk("issue_b", alu_b, eb);
      chk("issue_valid", {31'd0, rsp_valid}, 32'd0);
      chk("issue_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("cap_ctrl", {29'd0, alu_ctrl}, {29'd0, ec});
      chk("cap_a", alu_a, ea);
      chk("cap_b", alu_b, eb);
      chk("cap_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_result", rsp_result, er);
      chk("rsp_taken", {31'd0, rsp_taken}, {31'd0, et});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
      chk("rsp_ctrl", {29'd0, alu_ctrl}, 32'd0);
      chk("rsp_alu_a", alu_a, 32'd0);
      chk("rsp_alu_b", alu_b, 32'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_result", rsp_result, er);
         chk("stall_taken", {31'd0, rsp_taken}, {31'd0, et});
         chk("stall_err", {31'd0, rsp_err}, {31'd0, ee});
         chk("stall_ready", {31'd0, req_ready}, 32'd0);
         chk("stall_cnt", {28'd0, ops_done}, {28'd0, cnt_m});
      end
      chk("pre_cnt", {28'd0, ops_done}, {28'd0, cnt_m});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cnt_m = cnt_m + 1'b1;
      chk("done_cnt", {28'd0, ops_done}, {28'd0, cnt_m});
      chk("done_valid", {31'd0, rsp_valid}, 32'd0);
      chk("done_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      n_chk     = 0;
      n_err     = 0;
      cnt_m     = '0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_op1   = 32'd0;
      req_op2   = 32'd0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_taken", {31'd0, rsp_taken}, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_b", alu_b, 32'd0);
      chk("rst_cnt", {28'd0, ops_done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(4'd1, 32'd5, 32'd7, 0);
      run_op(4'd4, 32'h8000_0000, 32'd1, 0);
      run_op(4'd5, 32'h8000_0000, 32'd1, 0);
      run_op(4'd8, 32'd3, 32'd3, 0);
      run_op(4'd10, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd13, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd12, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5);
      run_op(4'hF, 32'd9, 32'd4, 0);
      run_op(4'd6, 32'd1, 32'd2, 1);

      // Abort mid-operation: reset while in CAPTURE.
      req_valid = 1'b1;
      req_op    = 4'd0;
      req_op1   = 32'd1;
      req_op2   = 32'd2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt_m = '0;
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_cnt", {28'd0, ops_done}, 32'd0);
      chk("abort_ctrl", {29'd0, alu_ctrl}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_quiet", {31'd0, rsp_valid}, 32'd0);
      end

      for (int k = 0; k < 60; k++) begin
         op = 4'($urandom_range(15));
         a  = $urandom;
         case ($urandom_range(3))
            0: b = a;
            1: b = 32'($urandom_range(3));
            default: b = $urandom;
         endcase
         if ($urandom_range(4) == 0) a = ~a;
         run_op(op, a, b, int'($urandom_range(2)));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
